// File: rtl/hello_pkg.sv
// hello_pkg: shared state encoding and message ROM
// for the hello_stream_dut character streamer.
package hello_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP,
    ST_DONE
  } state_t;

  localparam int HELLO_LEN = 11;

  localparam logic [8*HELLO_LEN-1:0] HELLO_MSG =
    "Hello World";

  // Character at position idx; past the text it is NUL.
  function automatic logic [7:0] hello_char(
    input int idx
  );
    logic [7:0] c;
    c = 8'h00;
    if (idx >= 0 && idx < HELLO_LEN)
      c = HELLO_MSG[8*(HELLO_LEN-1-idx) +: 8];
    return c;
  endfunction

endpackage

// File: rtl/dut_if.sv
// dut_if: bundles every hello_stream_dut port
// plus clock and reset for the verification env.
interface dut_if #(
  parameter int DATA_W = 8,
  parameter int REP_W  = 4
);
  logic              clk;
  logic              rstn;
  logic              start;
  logic [REP_W-1:0]  repeat_cnt;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              busy;
  logic              done;

  modport dut (
    input  clk, rstn, start, repeat_cnt,
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data,
    output out_last, busy, done
  );

  modport tb (
    output clk, rstn, start, repeat_cnt,
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data,
    input  out_last, busy, done
  );
endinterface

// File: rtl/hello_fifo.sv
// hello_fifo: power-of-two circular buffer used
// to hold echo bytes until they are streamed out.
module hello_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [AW:0]       count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CNT_MAX);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  // Pointers wrap naturally at DEPTH; count tracks fill.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push)
        wptr <= wptr + 1'b1;
      if (do_pop)
        rptr <= rptr + 1'b1;
      if (do_push && !do_pop)
        count <= count + 1'b1;
      else if (!do_push && do_pop)
        count <= count - 1'b1;
    end
  end

  // Storage array; contents need no reset.
  always_ff @(posedge clk) begin
    if (do_push)
      mem[wptr] <= wdata;
  end

endmodule

// File: rtl/hello_stream_dut.sv
// hello_stream_dut: streams "Hello World" (or echoed
// input bytes) as repeated framed messages.
module hello_stream_dut
  import hello_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int MSG_LEN = 11,
  parameter int MODE    = 0,
  parameter int DEPTH   = 16,
  parameter int GAP_CYC = 2,
  parameter int REP_W   = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [REP_W-1:0]  repeat_cnt,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int IDX_W =
    (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam int GAP_W =
    (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(MSG_LEN - 1);
  localparam logic [GAP_W-1:0] GAP_END =
    GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);

  state_t            state;
  state_t            state_nx;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_nx;
  logic [REP_W-1:0]  rem;
  logic [REP_W-1:0]  rem_nx;
  logic [GAP_W-1:0]  gap;
  logic [GAP_W-1:0]  gap_nx;
  logic              src_valid;
  logic [DATA_W-1:0] src_data;
  logic              sending;
  logic              xfer;

  assign sending   = (state == ST_SEND);
  assign out_valid = sending && src_valid;
  assign out_data  = out_valid ? src_data : '0;
  assign out_last  = sending && (idx == LAST_IDX);
  assign xfer      = out_valid && out_ready;
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);

  if (MODE == 1) begin : g_echo
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_head;

    hello_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (in_valid && in_ready),
      .pop   (xfer),
      .wdata (in_data),
      .rdata (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty)
    );

    assign in_ready  = rstn && !fifo_full;
    assign src_valid = !fifo_empty;
    assign src_data  = fifo_head;
  end else begin : g_rom
    logic unused_in;
    assign unused_in = ^{in_valid, in_data};
    assign in_ready  = 1'b0;
    assign src_valid = 1'b1;
    assign src_data  = DATA_W'(hello_char(int'(idx)));
  end

  // Sequencer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= ST_IDLE;
      idx   <= '0;
      rem   <= '0;
      gap   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      rem   <= rem_nx;
      gap   <= gap_nx;
    end
  end

  // Next-state: message framing, repeats, gaps.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    rem_nx   = rem;
    gap_nx   = gap;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_nx = ST_SEND;
          idx_nx   = '0;
          rem_nx   = (repeat_cnt == '0) ?
                     REP_ONE : repeat_cnt;
        end
      end
      ST_SEND: begin
        if (xfer) begin
          if (out_last) begin
            if (rem > REP_ONE) begin
              rem_nx   = rem - 1'b1;
              idx_nx   = '0;
              gap_nx   = '0;
              state_nx = (GAP_CYC == 0) ?
                         ST_SEND : ST_GAP;
            end else begin
              state_nx = ST_DONE;
            end
          end else begin
            idx_nx = idx + 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (gap == GAP_END)
          state_nx = ST_SEND;
        else
          gap_nx = gap + 1'b1;
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
        idx_nx   = '0;
        rem_nx   = '0;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_hello_stream_dut.sv
// tb_hello_stream_dut: randomized checks of the ROM
// streamer (MODE=0) and the echo streamer (MODE=1).
module tb_hello_stream_dut;

  int total = 0;
  int bad   = 0;
  string hello_s = "Hello World";

  dut_if #(.DATA_W(8), .REP_W(4)) b ();

  logic       e_start;
  logic [3:0] e_rep;
  logic       e_in_valid;
  logic       e_in_ready;
  logic [7:0] e_in_data;
  logic       e_out_valid;
  logic       e_out_ready;
  logic [7:0] e_out_data;
  logic       e_out_last;
  logic       e_busy;
  logic       e_done;

  hello_stream_dut #(.MODE(0)) u0 (
    .clk        (b.clk),
    .rstn       (b.rstn),
    .start      (b.start),
    .repeat_cnt (b.repeat_cnt),
    .in_valid   (b.in_valid),
    .in_ready   (b.in_ready),
    .in_data    (b.in_data),
    .out_valid  (b.out_valid),
    .out_ready  (b.out_ready),
    .out_data   (b.out_data),
    .out_last   (b.out_last),
    .busy       (b.busy),
    .done       (b.done)
  );

  hello_stream_dut #(.MODE(1), .DEPTH(16)) u1 (
    .clk        (b.clk),
    .rstn       (b.rstn),
    .start      (e_start),
    .repeat_cnt (e_rep),
    .in_valid   (e_in_valid),
    .in_ready   (e_in_ready),
    .in_data    (e_in_data),
    .out_valid  (e_out_valid),
    .out_ready  (e_out_ready),
    .out_data   (e_out_data),
    .out_last   (e_out_last),
    .busy       (e_busy),
    .done       (e_done)
  );

  initial begin
    b.clk = 1'b0;
    forever #5 b.clk = ~b.clk;
  end

  logic [7:0] got_d[$];
  bit         got_l[$];
  int         got_c[$];
  int done_cyc, done_n, inv_n, stall_bad, post_bad;

  // Records beats from u0 after a start; no checks.
  task automatic collect0(input int max_cyc,
                          input int pct,
                          input bit keep_start);
    logic       pv, pr, pl;
    logic [7:0] pd;
    got_d.delete();
    got_l.delete();
    got_c.delete();
    done_cyc = -1; done_n = 0; inv_n = 0;
    stall_bad = 0; post_bad = 0;
    pv = 0; pr = 0; pl = 0; pd = 0;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge b.clk);
      if (!keep_start || done_cyc >= 0)
        b.start = 1'b0;
      b.out_ready = ($urandom_range(99) < pct);
      #1;
      if (pv && !pr &&
          (!b.out_valid || b.out_data !== pd ||
           b.out_last !== pl))
        stall_bad++;
      if (b.done) begin
        done_n++;
        if (done_cyc < 0) done_cyc = c;
      end else if (done_cyc >= 0) begin
        if (b.busy || b.out_valid) post_bad++;
      end else if (!b.out_valid) begin
        inv_n++;
      end
      if (b.out_valid && b.out_ready) begin
        got_d.push_back(b.out_data);
        got_l.push_back(b.out_last);
        got_c.push_back(c);
      end
      pv = b.out_valid; pr = b.out_ready;
      pd = b.out_data;  pl = b.out_last;
      if (done_cyc >= 0 && c >= done_cyc + 2)
        break;
    end
  endtask

  task automatic test_reset();
    b.rstn = 0; b.start = 0; b.repeat_cnt = 0;
    b.in_valid = 0; b.in_data = 0; b.out_ready = 0;
    e_start = 0; e_rep = 0; e_in_valid = 0;
    e_in_data = 0; e_out_ready = 0;
    repeat (3) @(posedge b.clk);
    @(negedge b.clk);
    total++;
    if (b.out_valid !== 1'b0) begin bad++;
      $display("FAIL rst_valid got=%b want=0", b.out_valid); end
    total++;
    if (b.out_data !== 8'h00) begin bad++;
      $display("FAIL rst_data got=%h want=00", b.out_data); end
    total++;
    if (b.out_last !== 1'b0) begin bad++;
      $display("FAIL rst_last got=%b want=0", b.out_last); end
    total++;
    if (b.busy !== 1'b0 || b.done !== 1'b0) begin bad++;
      $display("FAIL rst_busy_done got=%b%b want=00",
               b.busy, b.done); end
    total++;
    if (e_in_ready !== 1'b0) begin bad++;
      $display("FAIL rst_in_ready got=%b want=0", e_in_ready); end
    b.rstn = 1;
    @(negedge b.clk); #1;
    total++;
    if (e_in_ready !== 1'b1) begin bad++;
      $display("FAIL post_rst_in_ready got=%b want=1",
               e_in_ready); end
    total++;
    if (b.in_ready !== 1'b0) begin bad++;
      $display("FAIL rom_in_ready got=%b want=0", b.in_ready); end
  endtask

  task automatic test_single();
    @(negedge b.clk);
    b.repeat_cnt = 4'd1; b.start = 1;
    collect0(40, 100, 0);
    total++;
    if (got_d.size() != 11) begin bad++;
      $display("FAIL single_len got=%0d want=11", got_d.size()); end
    for (int i = 0; i < 11 && i < got_d.size(); i++) begin
      total++;
      if (got_d[i] !== 8'(hello_s[i]) ||
          got_l[i] !== (i == 10)) begin bad++;
        $display("FAIL single_beat%0d got=%h/%b want=%h/%b",
                 i, got_d[i], got_l[i], 8'(hello_s[i]), i == 10);
      end
    end
    total++;
    if ((got_c.size() > 0 ? got_c[0] : -1) != 0) begin bad++;
      $display("FAIL single_first_cyc got=%0d want=0",
               got_c.size() > 0 ? got_c[0] : -1); end
    total++;
    if (done_cyc != 11 || done_n != 1) begin bad++;
      $display("FAIL single_done got=%0d/%0d want=11/1",
               done_cyc, done_n); end
    total++;
    if (post_bad != 0 || inv_n != 0) begin bad++;
      $display("FAIL single_idle got=%0d/%0d want=0/0",
               post_bad, inv_n); end
  endtask

  task automatic test_repeat();
    int nl;
    @(negedge b.clk);
    b.repeat_cnt = 4'd3; b.start = 1;
    collect0(100, 100, 0);
    total++;
    if (got_d.size() != 33) begin bad++;
      $display("FAIL rep3_len got=%0d want=33", got_d.size()); end
    nl = 0;
    for (int i = 0; i < got_d.size(); i++) begin
      if (got_l[i]) nl++;
      total++;
      if (got_d[i] !== 8'(hello_s[i % 11]) ||
          got_l[i] !== (i % 11 == 10)) begin bad++;
        $display("FAIL rep3_beat%0d got=%h want=%h",
                 i, got_d[i], 8'(hello_s[i % 11]));
      end
    end
    total++;
    if (nl != 3) begin bad++;
      $display("FAIL rep3_lasts got=%0d want=3", nl); end
    total++;
    if (inv_n != 4) begin bad++;
      $display("FAIL rep3_gap_cycles got=%0d want=4", inv_n); end
    if (got_c.size() == 33) begin
      total++;
      if (got_c[11] - got_c[10] != 3 ||
          got_c[22] - got_c[21] != 3) begin bad++;
        $display("FAIL rep3_gap_pos got=%0d,%0d want=3,3",
                 got_c[11] - got_c[10], got_c[22] - got_c[21]);
      end
    end
    total++;
    if (done_cyc != 37 || done_n != 1) begin bad++;
      $display("FAIL rep3_done got=%0d/%0d want=37/1",
               done_cyc, done_n); end
    @(negedge b.clk);
    b.repeat_cnt = 4'd0; b.start = 1;
    collect0(40, 100, 0);
    total++;
    if (got_d.size() != 11 || done_n != 1) begin bad++;
      $display("FAIL rep0_len got=%0d want=11", got_d.size()); end
  endtask

  task automatic test_random_ready();
    int r, pct;
    for (int it = 0; it < 4; it++) begin
      r = $urandom_range(3, 1);
      pct = $urandom_range(80, 30);
      @(negedge b.clk);
      b.repeat_cnt = 4'(r); b.start = 1;
      collect0(500, pct, it[0]);
      total++;
      if (got_d.size() != 11 * r) begin bad++;
        $display("FAIL rnd%0d_len got=%0d want=%0d",
                 it, got_d.size(), 11 * r); end
      for (int i = 0; i < got_d.size(); i++) begin
        total++;
        if (got_d[i] !== 8'(hello_s[i % 11]) ||
            got_l[i] !== (i % 11 == 10)) begin bad++;
          $display("FAIL rnd%0d_beat%0d got=%h want=%h",
                   it, i, got_d[i], 8'(hello_s[i % 11]));
        end
      end
      total++;
      if (stall_bad != 0) begin bad++;
        $display("FAIL rnd%0d_stall got=%0d want=0",
                 it, stall_bad); end
      total++;
      if (done_n != 1 || post_bad != 0) begin bad++;
        $display("FAIL rnd%0d_done got=%0d/%0d want=1/0",
                 it, done_n, post_bad); end
      total++;
      if (inv_n != 2 * (r - 1)) begin bad++;
        $display("FAIL rnd%0d_gaps got=%0d want=%0d",
                 it, inv_n, 2 * (r - 1)); end
    end
  endtask

  task automatic test_echo();
    logic [7:0] mq[$];
    logic [7:0] exp_d;
    int k;
    bit seen;
    for (int i = 0; i < 20; i++) begin
      @(negedge b.clk);
      e_in_valid = 1;
      e_in_data = 8'($urandom_range(255));
      #1;
      total++;
      if (e_in_ready !== (i < 16)) begin bad++;
        $display("FAIL echo_fill%0d got=%b want=%b",
                 i, e_in_ready, i < 16); end
      if (e_in_valid && e_in_ready)
        mq.push_back(e_in_data);
    end
    @(negedge b.clk);
    e_in_valid = 0; e_rep = 4'd1; e_start = 1;
    k = 0;
    for (int c = 0; c < 60 && k < 11; c++) begin
      @(negedge b.clk);
      e_start = 0; e_out_ready = 1;
      #1;
      if (e_out_valid && e_out_ready) begin
        exp_d = (mq.size() > 0) ? mq.pop_front() : 8'h00;
        total++;
        if (e_out_data !== exp_d ||
            e_out_last !== (k == 10)) begin bad++;
          $display("FAIL echo_beat%0d got=%h/%b want=%h/%b",
                   k, e_out_data, e_out_last, exp_d, k == 10);
        end
        k++;
      end
    end
    total++;
    if (k != 11) begin bad++;
      $display("FAIL echo_count got=%0d want=11", k); end
    @(negedge b.clk); #1;
    total++;
    if (e_done !== 1'b1 || e_busy !== 1'b1 ||
        e_in_ready !== 1'b1) begin bad++;
      $display("FAIL echo_end got=%b%b%b want=111",
               e_done, e_busy, e_in_ready); end
    @(negedge b.clk);
    e_rep = 4'd2; e_start = 1;
    k = 0; seen = 0;
    for (int c = 0; c < 600 && !seen; c++) begin
      @(negedge b.clk);
      e_start = 0;
      e_in_valid = ($urandom_range(1) == 1);
      e_in_data = 8'($urandom_range(255));
      e_out_ready = ($urandom_range(1) == 1);
      #1;
      total++;
      if (e_in_ready !== (mq.size() < 16)) begin bad++;
        $display("FAIL echo_ready got=%b want=%b",
                 e_in_ready, mq.size() < 16); end
      total++;
      if (e_out_valid && mq.size() == 0) begin bad++;
        $display("FAIL echo_valid_empty got=1 want=0"); end
      if (e_out_valid && e_out_ready && mq.size() > 0) begin
        exp_d = mq.pop_front();
        total++;
        if (e_out_data !== exp_d ||
            e_out_last !== (k % 11 == 10)) begin bad++;
          $display("FAIL echo2_beat%0d got=%h want=%h",
                   k, e_out_data, exp_d);
        end
        k++;
      end
      if (e_in_valid && e_in_ready)
        mq.push_back(e_in_data);
      if (e_done) seen = 1;
    end
    e_in_valid = 0; e_out_ready = 0;
    total++;
    if (!seen || k != 22) begin bad++;
      $display("FAIL echo2_count got=%0d/%b want=22/1",
               k, seen); end
  endtask

  task automatic test_mid_reset();
    int n;
    bit hit;
    @(negedge b.clk);
    b.repeat_cnt = 4'd2; b.start = 1;
    n = 0; hit = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge b.clk);
      b.start = 0; b.out_ready = 1;
      #1;
      if (b.out_valid && b.out_ready) begin
        n++;
        if (n == 17) begin
          total++;
          if (b.out_data !== 8'h20) begin bad++;
            $display("FAIL mid_idx5 got=%h want=20",
                     b.out_data); end
          b.rstn = 0; hit = 1;
          break;
        end
      end
    end
    total++;
    if (!hit) begin bad++;
      $display("FAIL mid_reach got=%0d want=17", n); end
    @(negedge b.clk); #1;
    total++;
    if (b.out_valid !== 1'b0 || b.busy !== 1'b0) begin bad++;
      $display("FAIL mid_rst got=%b%b want=00",
               b.out_valid, b.busy); end
    total++;
    if (e_in_ready !== 1'b0) begin bad++;
      $display("FAIL mid_in_ready got=%b want=0", e_in_ready); end
    b.rstn = 1;
    @(negedge b.clk);
    b.repeat_cnt = 4'd1; b.start = 1;
    collect0(40, 100, 0);
    total++;
    if (got_d.size() != 11 || got_d[0] !== 8'h48) begin bad++;
      $display("FAIL mid_restart got=%0d beats want=11 from 48",
               got_d.size()); end
    total++;
    if (e_in_ready !== 1'b1 || e_out_valid !== 1'b0) begin bad++;
      $display("FAIL mid_fifo got=%b%b want=10",
               e_in_ready, e_out_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_repeat();
    test_random_ready();
    test_echo();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule
